addsub_accumulator: RTL

Registered accumulate stage that sits directly downstream of the combinational `add_subtract` datapath. It accepts one operand and command per handshake and applies ADD, SUB, LOAD or CLEAR against an internal accumulator. ADD and SUB are computed by an instantiated `add_subtract`, and the result, carry and overflow are registered. Results go to the consumer over a valid/ready output handshake, with a sticky overflow flag and a completed-operation counter.

---
 rtl/addsub_accumulator_if.sv | 27 ++
 rtl/addsub_accumulator.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/addsub_accumulator_if.sv
// Handshake and result bundle for addsub_accumulator.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface addsub_accumulator_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] acc_o;
  logic             cout_o;
  logic             ovf_o;
  logic             ovf_sticky_o;
  logic [7:0]       count_o;

  modport slave (
    input  in_valid_i, op_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, acc_o, cout_o, ovf_o, ovf_sticky_o, count_o
  );

  modport master (
    output in_valid_i, op_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, acc_o, cout_o, ovf_o, ovf_sticky_o, count_o
  );
endinterface

// File: rtl/addsub_accumulator.sv
// Registered ADD/SUB/LOAD/CLEAR accumulator behind an add_subtract datapath.
// Optional feature: define ADDSUB_ACC_SAT_EN to clamp overflowing ADD/SUB results.
module add_subtract #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             add_sub,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;

  assign w_b_eff = b_i ^ {WIDTH{add_sub}};
  assign w_full  = {1'b0, a_i} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, add_sub};
  assign sum_o   = w_full[WIDTH-1:0];
  assign cout_o  = w_full[WIDTH];
  assign ovf_o   = (a_i[WIDTH-1] == w_b_eff[WIDTH-1]) & (w_full[WIDTH-1] != a_i[WIDTH-1]);
endmodule

// state | meaning
// IDLE  | ready for a command; in_ready_o=1
// EXEC  | compute from captured op/data and current acc; register results
// HOLD  | result presented; out_valid_o=1 until out_ready_i
module addsub_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  addsub_accumulator_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_acc;
  logic             r_cout;
  logic             r_ovf;
  logic             r_sticky;
  logic [7:0]       r_count;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_arith;
  logic [WIDTH-1:0] w_res_acc;
  logic             w_res_cout;
  logic             w_res_ovf;
  logic             w_res_sticky;
  logic [7:0]       w_res_count;

  add_subtract #(.WIDTH(WIDTH)) u_add_subtract (
    .a_i     (r_acc),
    .b_i     (r_data),
    .add_sub (r_op[0]),
    .sum_o   (w_sum),
    .cout_o  (w_cout),
    .ovf_o   (w_ovf)
  );

`ifdef ADDSUB_ACC_SAT_EN
  // Overflow direction follows the sign of acc: positive saturates to max, negative to min.
  assign w_arith = !w_ovf ? w_sum :
                   (r_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign w_arith = w_sum;
`endif

  always_comb begin
    w_res_acc    = r_acc;
    w_res_cout   = r_cout;
    w_res_ovf    = r_ovf;
    w_res_sticky = r_sticky;
    w_res_count  = r_count + 8'd1;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_res_acc    = w_arith;
        w_res_cout   = w_cout;
        w_res_ovf    = w_ovf;
        w_res_sticky = r_sticky | w_ovf;
      end
      OP_LOAD: begin
        w_res_acc  = r_data;
        w_res_cout = 1'b0;
        w_res_ovf  = 1'b0;
      end
      OP_CLEAR: begin
        w_res_acc    = '0;
        w_res_cout   = 1'b0;
        w_res_ovf    = 1'b0;
        w_res_sticky = 1'b0;
        w_res_count  = 8'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid_i) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_HOLD;
      S_HOLD:  if (bus.out_ready_i) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_data   <= '0;
      r_acc    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
      r_count  <= 8'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && bus.in_valid_i) begin
        r_op   <= bus.op_i;
        r_data <= bus.data_i;
      end
      if (r_state == S_EXEC) begin
        r_acc    <= w_res_acc;
        r_cout   <= w_res_cout;
        r_ovf    <= w_res_ovf;
        r_sticky <= w_res_sticky;
        r_count  <= w_res_count;
      end
    end
  end

  assign bus.in_ready_o   = (r_state == S_IDLE);
  assign bus.out_valid_o  = (r_state == S_HOLD);
  assign bus.acc_o        = r_acc;
  assign bus.cout_o       = r_cout;
  assign bus.ovf_o        = r_ovf;
  assign bus.ovf_sticky_o = r_sticky;
  assign bus.count_o      = r_count;
endmodule
